// File: rtl/video_fx_pipe_if.sv
// Pixel-stream bus: blanking, sync strobes and one RGB pixel per clock.
interface video_fx_pipe_if #(
  parameter int unsigned COLOR_BITS = 8
);
  logic                  blank;
  logic                  hsync;
  logic                  vsync;
  logic [COLOR_BITS-1:0] red;
  logic [COLOR_BITS-1:0] green;
  logic [COLOR_BITS-1:0] blue;

  modport master (output blank, hsync, vsync, red, green, blue);
  modport slave  (input  blank, hsync, vsync, red, green, blue);
endinterface

// File: rtl/video_fx_pipe.sv
// Pixel-stream effect stage: bypass, edge enhance, invert, grayscale; fixed 3-clock latency.
// Define VIDEO_FX_SCANLINE_EN to add CRT-style darkening of odd lines in non-bypass modes.
module video_fx_pipe #(
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned GAIN_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  video_fx_pipe_if.slave  src,
  video_fx_pipe_if.master dst
);
  localparam int unsigned CW = COLOR_BITS;
  localparam int unsigned HW = COLOR_BITS + 3;
  localparam int unsigned GW = COLOR_BITS + 2;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef struct packed {
    logic [CW-1:0] red;
    logic [CW-1:0] green;
    logic [CW-1:0] blue;
  } rgb_t;

  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
    rgb_t rgb;
  } pix_t;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_EDGE   = 2'd1,
    MODE_INVERT = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_t;

  localparam pix_t PIX_RST = {1'b1, (2 + 3 * CW)'(0)};

  pix_t          s0, s1, out_q;
  pix_t          in_c, fx_c;
  rgb_t          s2_rgb, left_c, right_c;
  logic          s2_blank, s2_vsync;
  logic          vsync_rise_c;
  logic [CW-1:0] gray_c;
  mode_t         active_mode;
`ifdef VIDEO_FX_SCANLINE_EN
  logic          s2_hsync, parity;
`endif

  // Unsharp term around the centre tap, clamped back into the channel range.
  function automatic logic [CW-1:0] sharpen(input logic [CW-1:0] l, input logic [CW-1:0] c,
                                            input logic [CW-1:0] r);
    logic signed [HW-1:0] h;
    logic signed [HW-1:0] y;
    h = $signed(HW'({c, 1'b0})) - $signed(HW'(l)) - $signed(HW'(r));
    y = $signed(HW'(c)) + (h >>> GAIN_SHIFT);
    if (y[HW-1]) return '0;
    if (y > $signed(HW'(CMAX))) return CMAX;
    return y[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] luma(input rgb_t p);
    logic [GW-1:0] sum;
    sum = GW'(p.red) + GW'({p.green, 1'b0}) + GW'(p.blue);
    return sum[GW-1:2];
  endfunction

  assign in_c         = {src.blank, src.hsync, src.vsync, src.red, src.green, src.blue};
  assign vsync_rise_c = s1.vsync & ~s2_vsync;

  // Effect on the centre pixel; neighbours in blanking fall back to the centre.
  always_comb begin
    left_c  = s2_blank ? s1.rgb : s2_rgb;
    right_c = s0.blank ? s1.rgb : s0.rgb;
    gray_c  = luma(s1.rgb);
    fx_c    = s1;
    case (active_mode)
      MODE_EDGE: begin
        fx_c.rgb.red   = sharpen(left_c.red,   s1.rgb.red,   right_c.red);
        fx_c.rgb.green = sharpen(left_c.green, s1.rgb.green, right_c.green);
        fx_c.rgb.blue  = sharpen(left_c.blue,  s1.rgb.blue,  right_c.blue);
      end
      MODE_INVERT: begin
        fx_c.rgb.red   = CMAX - s1.rgb.red;
        fx_c.rgb.green = CMAX - s1.rgb.green;
        fx_c.rgb.blue  = CMAX - s1.rgb.blue;
      end
      MODE_GRAY: fx_c.rgb = {gray_c, gray_c, gray_c};
      default: ;
    endcase
`ifdef VIDEO_FX_SCANLINE_EN
    if (parity && (active_mode != MODE_BYPASS)) begin
      fx_c.rgb.red   = fx_c.rgb.red >> 1;
      fx_c.rgb.green = fx_c.rgb.green >> 1;
      fx_c.rgb.blue  = fx_c.rgb.blue >> 1;
    end
`endif
    if (s1.blank) fx_c.rgb = '0;
  end

  // Delay line, output register and frame-aligned mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0          <= PIX_RST;
      s1          <= PIX_RST;
      s2_rgb      <= '0;
      s2_blank    <= 1'b1;
      s2_vsync    <= 1'b0;
      out_q       <= PIX_RST;
      active_mode <= MODE_BYPASS;
    end else begin
      s0       <= in_c;
      s1       <= s0;
      s2_rgb   <= s1.rgb;
      s2_blank <= s1.blank;
      s2_vsync <= s1.vsync;
      out_q    <= fx_c;
      if (vsync_rise_c) active_mode <= mode_t'(mode);
    end
  end

`ifdef VIDEO_FX_SCANLINE_EN
  // Line parity restarts each frame so the dark lines stay put vertically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_hsync <= 1'b0;
      parity   <= 1'b0;
    end else begin
      s2_hsync <= s1.hsync;
      if (vsync_rise_c)                parity <= 1'b0;
      else if (s1.hsync && !s2_hsync)  parity <= ~parity;
    end
  end
`endif

  assign dst.blank = out_q.blank;
  assign dst.hsync = out_q.hsync;
  assign dst.vsync = out_q.vsync;
  assign dst.red   = out_q.rgb.red;
  assign dst.green = out_q.rgb.green;
  assign dst.blue  = out_q.rgb.blue;
endmodule

// File: tb/tb_video_fx_pipe.sv
// Scoreboard bench for video_fx_pipe: directed and random pixel streams checked against
// a frame-level model of the effects, mode latch and line-edge rules.
`timescale 1ns/1ps
module tb_video_fx_pipe;
  localparam int CB   = 8;
  localparam int GS   = 1;
  localparam int MAXV = (1 << CB) - 1;

  typedef struct { bit blank; bit hs; bit vs; int r; int g; int b; int md; } px_t;
  typedef struct { bit blank; bit hs; bit vs; int r; int g; int b; } ex_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode  = 2'd0;

  video_fx_pipe_if #(.COLOR_BITS(CB)) src_bus ();
  video_fx_pipe_if #(.COLOR_BITS(CB)) dst_bus ();

  video_fx_pipe #(.COLOR_BITS(CB), .GAIN_SHIFT(GS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .src(src_bus), .dst(dst_bus)
  );

  always #20 clk = ~clk;

  px_t stim[$];
  ex_t expq[$];
  ex_t sb[$];
  ex_t mon_e;
  int  checks = 0;
  int  errors = 0;

  function automatic ex_t reset_ex();
    ex_t e;
    e.blank = 1'b1; e.hs = 1'b0; e.vs = 1'b0; e.r = 0; e.g = 0; e.b = 0;
    return e;
  endfunction

  task automatic compare(input string name, input ex_t want);
    ex_t got;
    got.blank = dst_bus.blank; got.hs = dst_bus.hsync; got.vs = dst_bus.vsync;
    got.r = int'(dst_bus.red); got.g = int'(dst_bus.green); got.b = int'(dst_bus.blue);
    checks++;
    if (got.blank != want.blank || got.hs != want.hs || got.vs != want.vs ||
        got.r != want.r || got.g != want.g || got.b != want.b) begin
      errors++;
      $display("FAIL %s @%0t: got blank=%0b hs=%0b vs=%0b rgb=%0h/%0h/%0h, required blank=%0b hs=%0b vs=%0b rgb=%0h/%0h/%0h",
               name, $time, got.blank, got.hs, got.vs, got.r, got.g, got.b,
               want.blank, want.hs, want.vs, want.r, want.g, want.b);
    end
  endtask

  // Monitor: reset values while reset is held, otherwise one scoreboard entry per clock.
  always @(negedge clk) begin
    if (!rst_n) compare("reset_hold", reset_ex());
    else if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      compare("pixel", mon_e);
    end
  end

  // ---------------- stimulus builders ----------------
  function automatic void add(bit bl, bit hs, bit vs, int r, int g, int b, int md);
    px_t p;
    p.blank = bl; p.hs = hs; p.vs = vs; p.r = r; p.g = g; p.b = b; p.md = md;
    stim.push_back(p);
  endfunction

  function automatic void add_blank(int n, bit hs, bit vs, int md);
    for (int i = 0; i < n; i++) add(1'b1, hs, vs, 0, 0, 0, md);
  endfunction

  function automatic void vsync_pulse(int md);
    add_blank(2, 1'b0, 1'b0, md); add_blank(2, 1'b0, 1'b1, md); add_blank(3, 1'b0, 1'b0, md);
  endfunction

  function automatic void line_start(int md);
    add_blank(1, 1'b0, 1'b0, md); add_blank(1, 1'b1, 1'b0, md); add_blank(2, 1'b0, 1'b0, md);
  endfunction

  function automatic void rand_line(int n, int md);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, 1'b0, $urandom_range(0, MAXV), $urandom_range(0, MAXV),
          $urandom_range(0, MAXV), md);
  endfunction

  function automatic void const_line(int n, int v, int md);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, v, v, v, md);
  endfunction

  function automatic void rand_frames(int nf);
    for (int f = 0; f < nf; f++) begin
      vsync_pulse($urandom_range(0, 3));
      for (int l = 0; l < 3; l++) begin
        line_start($urandom_range(0, 3));
        rand_line($urandom_range(3, 10), $urandom_range(0, 3));
      end
    end
    add_blank(3, 1'b0, 1'b0, 0);
  endfunction

  // ---------------- reference model ----------------
  function automatic int sat(int v);
    return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
  endfunction

  function automatic int fx_edge(int l, int c, int r);
    int h;
    h = 2 * c - l - r;
    return sat(c + (h >>> GS));
  endfunction

  // Walks the stream once; the mode latched at a centre-stage vsync rise is the
  // request present two pixels later, and applies from the following pixel on.
  function automatic void build_model();
    int n;
    int act;
    bit par, pvs, phs;
    n = stim.size(); act = 0; par = 1'b0; pvs = 1'b0; phs = 1'b0;
    expq.delete();
    for (int j = 0; j < n; j++) begin
      px_t c, l, r;
      int cl[3], cc[3], cr[3], o[3];
      ex_t e;
      c = stim[j];
      l = c;
      if (j > 0) begin
        if (!stim[j-1].blank) l = stim[j-1];
      end
      r = stim[(j + 1 < n) ? j + 1 : n - 1];
      if (r.blank) r = c;
      cl = '{l.r, l.g, l.b}; cc = '{c.r, c.g, c.b}; cr = '{r.r, r.g, r.b};
      for (int k = 0; k < 3; k++) begin
        case (act)
          1:       o[k] = fx_edge(cl[k], cc[k], cr[k]);
          2:       o[k] = MAXV - cc[k];
          3:       o[k] = (c.r + 2 * c.g + c.b) / 4;
          default: o[k] = cc[k];
        endcase
`ifdef VIDEO_FX_SCANLINE_EN
        if (par && act != 0) o[k] = o[k] / 2;
`endif
        if (c.blank) o[k] = 0;
      end
      e.blank = c.blank; e.hs = c.hs; e.vs = c.vs; e.r = o[0]; e.g = o[1]; e.b = o[2];
      expq.push_back(e);
      if (c.vs && !pvs) begin
        act = stim[(j + 2 < n) ? j + 2 : n - 1].md;
        par = 1'b0;
      end else if (c.hs && !phs) par = !par;
      pvs = c.vs; phs = c.hs;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input px_t p);
    src_bus.blank = p.blank; src_bus.hsync = p.hs; src_bus.vsync = p.vs;
    src_bus.red = CB'(p.r); src_bus.green = CB'(p.g); src_bus.blue = CB'(p.b);
    mode = 2'(p.md);
  endtask

  task automatic drive_idle();
    px_t p;
    p.blank = 1'b1; p.hs = 1'b0; p.vs = 1'b0; p.r = 0; p.g = 0; p.b = 0; p.md = 0;
    drive(p);
  endtask

  // Asserts reset mid-cycle; outputs must snap to reset values without a clock.
  task automatic hold_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    drive_idle();
    #1 compare("reset_async", reset_ex());
    repeat (2) @(posedge clk);
  endtask

  task automatic run_segment(input int abort_at);
    build_model();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) sb.push_back(reset_ex());
    for (int j = 0; j < stim.size(); j++) begin
      @(negedge clk);
      if (j == abort_at) begin
        hold_reset();
        stim.delete();
        return;
      end
      drive(stim[j]);
      sb.push_back(expq[j]);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    hold_reset();
    stim.delete();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    repeat (3) @(posedge clk);

    // Bypass straight after reset, plus timing alignment.
    add(1'b0, 1'b0, 1'b0, 'h40, 'h80, 'hC0, 0);
    rand_line(6, 0); line_start(0); rand_line(8, 0); add_blank(3, 1'b0, 1'b0, 0);
    run_segment(-1);

    // Edge enhance: directed line, halo-free edges, saturation, 1-clock strobes.
    vsync_pulse(1); line_start(1);
    add(1'b0, 1'b0, 1'b0, 'h10, 0, 0, 1); add(1'b0, 1'b0, 1'b0, 'h10, 0, 0, 1);
    add(1'b0, 1'b0, 1'b0, 'h80, 0, 0, 1); add(1'b0, 1'b0, 1'b0, 'h10, 0, 0, 1);
    add(1'b0, 1'b0, 1'b0, 'h10, 0, 0, 1);
    line_start(1);
    add(1'b0, 1'b0, 1'b0, 'hFF, 'hFF, 'hFF, 1); const_line(2, 0, 1);
    add(1'b0, 1'b0, 1'b0, 'hFF, 'hFC, 'hF0, 1); const_line(2, 0, 1);
    add(1'b0, 1'b0, 1'b0, 'hFF, 0, 'h80, 1);
    line_start(1); rand_line(12, 1); add_blank(1, 1'b0, 1'b1, 1);
    add_blank(3, 1'b0, 1'b0, 1);
    run_segment(-1);

    // Mid-frame request stays pending until the next frame.
    vsync_pulse(2); line_start(2);
    add(1'b0, 1'b0, 1'b0, 'h40, 'h80, 'hC0, 2); rand_line(4, 3);
    line_start(3); add(1'b0, 1'b0, 1'b0, 'h40, 'h80, 'hC0, 3);
    vsync_pulse(3); line_start(3);
    add(1'b0, 1'b0, 1'b0, 'h40, 'h80, 'hC0, 3); rand_line(4, 3);
    add_blank(3, 1'b0, 1'b0, 3);
    run_segment(-1);

    // Flat frames (scanline pattern when enabled), then random frames.
    vsync_pulse(2);
    for (int l = 0; l < 4; l++) begin line_start(2); const_line(6, 0, 2); end
    vsync_pulse(0);
    for (int l = 0; l < 2; l++) begin line_start(0); const_line(6, 0, 0); end
    rand_frames(6);
    run_segment(-1);

    // Reset in the middle of a stream, then bypass until a vsync latches a mode.
    rand_frames(4);
    run_segment(stim.size() / 2);
    line_start(3); rand_line(8, 3); rand_frames(3);
    run_segment(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
